// File: rtl/alu_bist_if.sv
// ALU stimulus/response bus between the BIST controller (master) and the ALU under test (slave).
interface alu_bist_if;
    logic [5:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] out;
    logic        zero;
    logic        great;
    logic        overflow;

    modport master (
        output alu_op, a, b, shamt,
        input  out, zero, great, overflow
    );

    modport slave (
        input  alu_op, a, b, shamt,
        output out, zero, great, overflow
    );
endinterface

// File: rtl/alu_bist.sv
// Built-in self-test for a combinational ALU: sweeps opcodes with LFSR operands
// and compacts every result plus flags into a 32-bit MISR signature.
module alu_bist #(
    parameter int unsigned PATTERNS = 256,
    parameter logic [5:0]  OP_LAST  = 6'd20,
    parameter logic [31:0] SEED     = 32'hACE1_2468,
    parameter logic [31:0] GOLDEN   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    alu_bist_if.master        alu_bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       signature
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned SH_W   = 5;
    localparam int unsigned CNT_W  = 16;

    localparam logic [DATA_W-1:0] LFSR_POLY = 32'h0040_0007;
    localparam logic [DATA_W-1:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PATTERNS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_lfsr;
    logic [CNT_W-1:0]    r_cnt;
    logic [OP_W-1:0]     r_alu_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [SH_W-1:0]     r_shamt;
    logic [DATA_W-1:0]   r_sig;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;

    logic [DATA_W-1:0]   w_lfsr_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [OP_W-1:0]     w_alu_op_nxt;
    logic [DATA_W-1:0]   w_a_nxt;
    logic [DATA_W-1:0]   w_b_nxt;
    logic [SH_W-1:0]     w_shamt_nxt;
    logic [DATA_W-1:0]   w_sig_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_pass_nxt;

    logic [DATA_W-1:0]   w_lfsr_step1;
    logic [DATA_W-1:0]   w_lfsr_step2;
    logic [DATA_W-1:0]   w_sig_upd;
    logic                w_last_vec;
    logic                w_last_op;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x);
        return {x[DATA_W-2:0], 1'b0} ^ (x[DATA_W-1] ? LFSR_POLY : '0);
    endfunction

    // Two LFSR steps per vector: operand b is the first step, the register advances past it.
    assign w_lfsr_step1 = lfsr_step(r_lfsr);
    assign w_lfsr_step2 = lfsr_step(w_lfsr_step1);

    assign w_sig_upd = {r_sig[DATA_W-2:0], 1'b0}
                     ^ (r_sig[DATA_W-1] ? MISR_POLY : '0)
                     ^ alu_bus.out
                     ^ {29'd0, alu_bus.zero, alu_bus.great, alu_bus.overflow};

    assign w_last_vec = (r_cnt == CNT_LAST);
    assign w_last_op  = (r_alu_op == OP_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE,
            S_DONE:    if (start) w_state_nxt = S_LOAD;
            S_LOAD:    w_state_nxt = S_APPLY;
            S_APPLY:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = (w_last_vec && w_last_op) ? S_DONE : S_APPLY;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values; everything holds unless the current state updates it
    always_comb begin
        w_lfsr_nxt   = r_lfsr;
        w_cnt_nxt    = r_cnt;
        w_alu_op_nxt = r_alu_op;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_shamt_nxt  = r_shamt;
        w_sig_nxt    = r_sig;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_pass_nxt   = r_pass;
        case (r_state)
            S_IDLE,
            S_DONE: begin
                if (start) begin
                    w_busy_nxt = 1'b1;
                    w_done_nxt = 1'b0;
                    w_pass_nxt = 1'b0;
                end
            end
            S_LOAD: begin
                w_lfsr_nxt   = SEED;
                w_sig_nxt    = '0;
                w_alu_op_nxt = '0;
                w_cnt_nxt    = '0;
                w_done_nxt   = 1'b0;
                w_pass_nxt   = 1'b0;
            end
            S_APPLY: begin
                w_a_nxt     = r_lfsr;
                w_b_nxt     = w_lfsr_step1;
                w_shamt_nxt = w_lfsr_step1[SH_W-1:0];
                w_lfsr_nxt  = w_lfsr_step2;
            end
            S_CAPTURE: begin
                w_sig_nxt = w_sig_upd;
                if (!w_last_vec) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else if (!w_last_op) begin
                    w_cnt_nxt    = '0;
                    w_alu_op_nxt = r_alu_op + OP_W'(1);
                end else begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                    w_pass_nxt = (w_sig_upd == GOLDEN);
                end
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
                w_pass_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr   <= SEED;
            r_cnt    <= '0;
            r_alu_op <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_shamt  <= '0;
            r_sig    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_lfsr   <= w_lfsr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_alu_op <= w_alu_op_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_shamt  <= w_shamt_nxt;
            r_sig    <= w_sig_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_pass   <= w_pass_nxt;
        end
    end

    assign alu_bus.alu_op = r_alu_op;
    assign alu_bus.a      = r_a;
    assign alu_bus.b      = r_b;
    assign alu_bus.shamt  = r_shamt;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign signature      = r_sig;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a default-parameter instance driven by a behavioural ALU and
// a minimal instance driven by a constant stub, both checked against a loop-level model.
module tb_alu_bist;

    localparam int unsigned N_PAT    = 256;
    localparam int unsigned N_OPS    = 21;
    localparam int unsigned RUN_CYC  = 2 * N_PAT * N_OPS + 1;
    localparam logic [31:0] DEF_SEED = 32'hACE1_2468;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;

    logic        start_s;
    logic        busy_s;
    logic        done_s;
    logic        pass_s;
    logic [31:0] signature_s;

    logic        fault_en;
    logic [31:0] fault_a;

    int unsigned n_chk;
    int unsigned n_pass;

    alu_bist_if bus_m ();
    alu_bist_if bus_s ();

    alu_bist dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .alu_bus   (bus_m),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    alu_bist #(
        .PATTERNS (1),
        .OP_LAST  (6'd0),
        .SEED     (32'h0000_0001),
        .GOLDEN   (32'h0000_0003)
    ) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s),
        .alu_bus   (bus_s),
        .busy      (busy_s),
        .done      (done_s),
        .pass      (pass_s),
        .signature (signature_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {out, zero, great, overflow}
    function automatic logic [34:0] alu_model(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic        o;
        r = '0;
        o = 1'b0;
        case (op)
            6'd0:  begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            6'd1:  begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            6'd2:  r = a & b;
            6'd3:  r = a | b;
            6'd4:  r = a ^ b;
            6'd5:  r = ~(a | b);
            6'd6:  r = a << sh;
            6'd7:  r = a >> sh;
            6'd8:  r = $signed(a) >>> sh;
            6'd9:  r = {31'd0, $signed(a) < $signed(b)};
            6'd10: r = {31'd0, a < b};
            6'd11: r = a * b;
            6'd12: r = b << sh;
            6'd13: r = b >> sh;
            6'd14: r = a + 32'd1;
            6'd15: r = a - 32'd1;
            6'd16: r = ~a;
            6'd17: r = {a[15:0], b[15:0]};
            6'd18: r = (a << sh) | (a >> (6'd32 - {1'b0, sh}));
            6'd19: r = a;
            6'd20: r = b;
            default: r = '0;
        endcase
        return {r, r == 32'd0, $signed(a) > $signed(b), o};
    endfunction

    assign {bus_m.out, bus_m.zero, bus_m.great, bus_m.overflow} =
        alu_model(bus_m.alu_op, bus_m.a, bus_m.b, bus_m.shamt)
        ^ {34'd0, fault_en && (bus_m.a == fault_a)};

    assign bus_s.out      = 32'h0000_0003;
    assign bus_s.zero     = 1'b0;
    assign bus_s.great    = 1'b0;
    assign bus_s.overflow = 1'b0;

    function automatic logic [31:0] nx(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? 32'h0040_0007 : 32'h0);
    endfunction

    // Whole-run reference: every opcode, every vector, folded into the signature
    function automatic void model_run(input bit fen, input logic [31:0] fa,
                                      output logic [31:0] sig, output logic [31:0] la,
                                      output logic [31:0] lb, output logic [4:0] lsh);
        logic [31:0] x;
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] r;
        x   = DEF_SEED;
        sig = '0;
        la  = '0;
        lb  = '0;
        lsh = '0;
        for (int op = 0; op < int'(N_OPS); op++) begin
            for (int i = 0; i < int'(N_PAT); i++) begin
                a = x;
                b = nx(x);
                x = nx(b);
                r = alu_model(6'(op), a, b, b[4:0]);
                if (fen && a == fa) r[0] = ~r[0];
                sig = {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 32'h0)
                    ^ r[34:3] ^ {29'd0, r[2:0]};
                la  = a;
                lb  = b;
                lsh = b[4:0];
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Launch a run from a negedge and wait (bounded) for done; counts busy cycles.
    task automatic do_run(input bit disturb, output int unsigned bcyc, output logic [31:0] sig);
        int unsigned n;
        bcyc  = 0;
        n     = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && n < 3 * RUN_CYC) begin
            if (busy) bcyc++;
            if (n == 1) chk("done_cleared", 32'(done), 32'd0);
            if (n == 2) begin
                chk("first_op", 32'(bus_m.alu_op), 32'd0);
                chk("first_a", bus_m.a, DEF_SEED);
                chk("first_b", bus_m.b, nx(DEF_SEED));
            end
            start = disturb && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("run_done", 32'(done), 32'd1);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        sig = signature;
    endtask

    initial begin
        logic [31:0] sig_ref, sig_flt, sig_run, x;
        logic [31:0] la, lb;
        logic [4:0]  lsh;
        int unsigned bcyc, v;

        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        start_s  = 1'b0;
        fault_en = 1'b0;
        fault_a  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_sig", signature, 32'd0);
        chk("rst_op", 32'(bus_m.alu_op), 32'd0);
        chk("rst_a", bus_m.a, 32'd0);
        chk("rst_b", bus_m.b, 32'd0);
        chk("rst_shamt", 32'(bus_m.shamt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Minimal configuration: one vector, one opcode
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (2) @(negedge clk);
        chk("s_op", 32'(bus_s.alu_op), 32'd0);
        chk("s_a", bus_s.a, 32'd1);
        chk("s_b", bus_s.b, 32'd2);
        chk("s_shamt", 32'(bus_s.shamt), 32'd2);
        chk("s_done_early", 32'(done_s), 32'd0);
        @(negedge clk);
        chk("s_done", 32'(done_s), 32'd1);
        chk("s_sig", signature_s, 32'h0000_0003);
        chk("s_pass", 32'(pass_s), 32'd1);
        chk("s_busy", 32'(busy_s), 32'd0);

        // Fault-free reference run
        model_run(1'b0, 32'd0, sig_ref, la, lb, lsh);
        do_run(1'b0, bcyc, sig_run);
        chk("busy_cycles", 32'(bcyc), 32'(RUN_CYC));
        chk("sig", sig_run, sig_ref);
        chk("pass", 32'(pass), 32'(sig_ref == 32'd0));
        chk("last_op", 32'(bus_m.alu_op), 32'd20);
        chk("last_a", bus_m.a, la);
        chk("last_b", bus_m.b, lb);
        chk("last_shamt", 32'(bus_m.shamt), 32'(lsh));
        repeat (5) @(negedge clk);
        chk("hold_sig", signature, sig_ref);
        chk("hold_done", 32'(done), 32'd1);

        // Back-to-back restart from DONE
        do_run(1'b0, bcyc, sig_run);
        chk("repeat_sig", sig_run, sig_ref);

        // Start pulses while busy must be ignored
        do_run(1'b1, bcyc, sig_run);
        chk("disturb_cycles", 32'(bcyc), 32'(RUN_CYC));
        chk("disturb_sig", sig_run, sig_ref);

        // Single overflow flip on one randomly chosen vector
        v = $urandom_range(0, N_PAT * N_OPS - 1);
        x = DEF_SEED;
        for (int i = 0; i < int'(v); i++) x = nx(nx(x));
        fault_a  = x;
        fault_en = 1'b1;
        model_run(1'b1, fault_a, sig_flt, la, lb, lsh);
        do_run(1'b0, bcyc, sig_run);
        fault_en = 1'b0;
        chk("fault_sig", sig_run, sig_flt);
        chk("fault_differs", 32'(sig_run != sig_ref), 32'd1);
        chk("fault_pass", 32'(pass), 32'(sig_flt == 32'd0));

        // Asynchronous reset in the middle of a CAPTURE cycle
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * $urandom_range(1, 100)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_pass", 32'(pass), 32'd0);
        chk("arst_sig", signature, 32'd0);
        chk("arst_op", 32'(bus_m.alu_op), 32'd0);
        chk("arst_a", bus_m.a, 32'd0);
        chk("arst_b", bus_m.b, 32'd0);
        chk("arst_shamt", 32'(bus_m.shamt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_restart_busy", 32'(busy), 32'd0);
        chk("no_restart_done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter PATTERNS, default 256, number of pseudo-random vectors applied per ALU opcode (legal range 1..65535).
REQ-002 Parameter OP_LAST, default 6'd20, highest alu_op value swept; opcodes 0..OP_LAST inclusive are exercised.
REQ-003 Parameter SEED, default 32'hACE1_2468, LFSR load value at start; must be non-zero.
REQ-004 Parameter GOLDEN, default 32'h0000_0000, expected final signature.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle request to run the self-test.
REQ-008 alu_op  output  6  opcode driven to the ALU under test.
REQ-009 a / b  output  32 each  operands driven to the ALU.
REQ-010 shamt  output  5  shift amount driven to the ALU.
REQ-011 out  input  32  ALU result (ALU is combinational, same-cycle response).
REQ-012 zero / great / overflow  input  1 each  ALU flags.
REQ-013 busy  output  1  high while a test run is in progress.
REQ-014 done  output  1  high from run completion until next start or reset.
REQ-015 pass  output  1  valid when done=1; 1 iff signature == GOLDEN.
REQ-016 signature  output  32  current MISR contents.

Function
REQ-017 FSM states IDLE, LOAD, APPLY, CAPTURE, DONE; all outputs registered.
REQ-018 IDLE or DONE with start=1 -> LOAD; start in LOAD/APPLY/CAPTURE ignored.
REQ-019 LOAD (1 cycle): lfsr<=SEED, signature<=0, alu_op<=0, vector count<=0, done<=0, pass<=0; -> APPLY.
REQ-020 LFSR step next(x) = (x<<1) ^ (x[31] ? 32'h0040_0007 : 0), 32-bit.
REQ-021 APPLY (1 cycle): a<=lfsr, b<=next(lfsr), shamt<=next(lfsr)[4:0], lfsr<=next(next(lfsr)); -> CAPTURE.
REQ-022 alu_op, a, b, shamt shall be stable throughout CAPTURE (ALU outputs sampled at end of CAPTURE).
REQ-023 CAPTURE: signature <= (sig<<1) ^ (sig[31] ? 32'h04C1_1DB7 : 0) ^ out ^ {29'd0, zero, great, overflow}.
REQ-024 CAPTURE, count < PATTERNS-1: count++ -> APPLY.
REQ-025 CAPTURE, count == PATTERNS-1 and alu_op < OP_LAST: count<=0, alu_op++ -> APPLY; LFSR not reseeded.
REQ-026 CAPTURE, count == PATTERNS-1 and alu_op == OP_LAST: -> DONE; pass computed from the updated signature.
REQ-027 busy=1 in LOAD, APPLY, CAPTURE; 0 otherwise; done=1 only in DONE.
REQ-028 Run length: start sampled at edge k -> done=1 after edge k+1+2*PATTERNS*(OP_LAST+1).
REQ-029 In DONE, alu_op/a/b/shamt/signature hold last values; counters never wrap mid-run.

Reset
REQ-030 rst_n=0 asynchronously forces IDLE; alu_op, a, b, shamt, signature, busy, done, pass = 0; lfsr = SEED.
REQ-031 Reset asserted mid-run aborts immediately; no partial done/pass; next run requires new start.

Verification
REQ-032 Reset: rst_n low mid-CAPTURE -> all outputs 0 same cycle without clock edge, state IDLE.
REQ-033 PATTERNS=1, OP_LAST=0, SEED=1, ALU stub out=32'h3 flags 0 -> applied alu_op=0, a=1, b=2, shamt=2; signature=32'h0000_0003, done=1 three cycles after start.
REQ-034 Defaults with real ALU: busy high exactly 2*256*21+1 = 10753 cycles; done at that edge; pass=0 with GOLDEN=0 unless signature matches.
REQ-035 Determinism: two back-to-back runs (start in DONE) produce identical signature; second run clears done on LOAD.
REQ-036 start pulses during busy -> no restart, cycle count unchanged, final signature identical to undisturbed run.
REQ-037 Fault sensitivity: stub flips overflow once on one vector -> final signature differs from fault-free run, pass=0 when GOLDEN set to fault-free value.
